// File: rtl/polyvec_make_hint_stream_pkg.sv
// Shared constants and types for the make-hint stream block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: modulus Q, GAMMA2/OMEGA for both parameter sets, coefficient width,
// FSM state type.
package polyvec_make_hint_stream_pkg;

    localparam int Q         = 8380417;
    localparam int COEFF_W   = 32;

    // Low-order rounding bounds for the two parameter sets.
    localparam int GAMMA2_88 = (Q - 1) / 88;   // 95232
    localparam int GAMMA2_32 = (Q - 1) / 32;   // 261888

    // Maximum hint counts paired with the bounds above.
    localparam int OMEGA_88  = 80;
    localparam int OMEGA_32  = 55;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/polyvec_make_hint_stream_make_hint_lane.sv
// Single-coefficient hint: set when a0 leaves the rounding window (-GAMMA2, GAMMA2].
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: a0, a1 are signed COEFF_W-bit coefficients; h is the resulting hint bit.
module make_hint_lane
    import polyvec_make_hint_stream_pkg::*;
#(
    parameter int GAMMA2 = GAMMA2_32
) (
    input  logic signed [COEFF_W-1:0] a0,
    input  logic signed [COEFF_W-1:0] a1,
    output logic                      h
);

    localparam logic signed [COEFF_W-1:0] POS_BOUND = COEFF_W'(GAMMA2);
    localparam logic signed [COEFF_W-1:0] NEG_BOUND = -POS_BOUND;

    // Exactly -GAMMA2 is the one point where the high part decides the hint.
    always_comb begin
        h = (a0 > POS_BOUND) || (a0 < NEG_BOUND) ||
            ((a0 == NEG_BOUND) && (a1 != '0));
    end

endmodule

// File: rtl/polyvec_make_hint_stream.sv
// Streams a K-polynomial vector of (a0,a1) beats and emits LANES hint bits per beat
// with a running hint total. Latency: one cycle from input acceptance to h_out.
// Backpressure: single output register; in_ready drops while out_valid && !out_ready.
// Ports: clk/rst (async, active-high), start, in_valid/in_ready/a0_in/a1_in,
// out_valid/out_ready/h_out/out_poly, busy, done, hint_count.
// Optional: define MAKE_HINT_OMEGA_CHECK_EN to add the sticky omega_fail output.
module polyvec_make_hint_stream
    import polyvec_make_hint_stream_pkg::*;
#(
    parameter int K      = 6,
    parameter int N      = 256,
    parameter int LANES  = 4,
    parameter int GAMMA2 = GAMMA2_32,
    parameter int OMEGA  = OMEGA_32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [COEFF_W*LANES-1:0]     a0_in,
    input  logic [COEFF_W*LANES-1:0]     a1_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES-1:0]             h_out,
    output logic [$clog2(K)-1:0]         out_poly,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(K*N+1)-1:0]     hint_count
`ifdef MAKE_HINT_OMEGA_CHECK_EN
    ,
    output logic                         omega_fail
`endif
);

    localparam int BPP = N / LANES;                       // beats per polynomial
    localparam int BW  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int PW  = $clog2(K);
    localparam int CW  = $clog2(K*N+1);

    // Elaboration-time sanity on the geometry.
    if ((N % LANES) != 0 || OMEGA < 0 || OMEGA > K*N) begin : g_bad_params
        $error("polyvec_make_hint_stream: N must be a multiple of LANES and OMEGA within 0..K*N");
    end

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic [PW-1:0]   poly_idx;
    logic [LANES-1:0] h_vec;
    logic [CW-1:0]   h_pop;
    logic [CW-1:0]   hint_sum;
    logic            accept;
    logic            last_beat;
    logic            out_fire;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        make_hint_lane #(
            .GAMMA2 (GAMMA2)
        ) u_lane (
            .a0 (a0_in[COEFF_W*j +: COEFF_W]),
            .a1 (a1_in[COEFF_W*j +: COEFF_W]),
            .h  (h_vec[j])
        );
    end

    always_comb begin
        h_pop = '0;
        for (int j = 0; j < LANES; j++) begin
            h_pop = h_pop + CW'(h_vec[j]);
        end
    end

    // A new beat may enter while the output slot is empty or emptying this cycle.
    assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_beat = (beat_cnt == BW'(BPP - 1)) && (poly_idx == PW'(K - 1));
    assign hint_sum  = hint_count + h_pop;

`ifdef MAKE_HINT_OMEGA_CHECK_EN
    localparam logic [CW-1:0] OMEGA_C = CW'(OMEGA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            omega_fail <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            omega_fail <= 1'b0;
        end else if (accept && (hint_sum > OMEGA_C)) begin
            omega_fail <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            poly_idx   <= '0;
            out_valid  <= 1'b0;
            h_out      <= '0;
            out_poly   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hint_count <= '0;
        end else begin
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        beat_cnt   <= '0;
                        poly_idx   <= '0;
                        hint_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept && last_beat) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Only the final beat can be in the output slot here.
                    if (out_fire) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (accept) begin
                h_out      <= h_vec;
                out_poly   <= poly_idx;
                out_valid  <= 1'b1;
                hint_count <= hint_sum;
                if (beat_cnt == BW'(BPP - 1)) begin
                    beat_cnt <= '0;
                    poly_idx <= last_beat ? '0 : poly_idx + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_polyvec_make_hint_stream.sv
// Self-checking bench for polyvec_make_hint_stream: directed passes against a
// per-beat expected-hint table built from the hint rule, plus literal pins.
// Latency/backpressure exercised: stalls, random flow, abort, ignored start.
module tb_polyvec_make_hint_stream;

    localparam int K     = 6;
    localparam int N     = 256;
    localparam int LANES = 4;
    localparam int BPP   = N / LANES;
    localparam int NB    = K * N / LANES;
    localparam int G     = 261888;
    localparam int OMEGA = 55;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   in_valid;
    logic                   in_ready;
    logic [32*LANES-1:0]    a0_in;
    logic [32*LANES-1:0]    a1_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES-1:0]       h_out;
    logic [2:0]             out_poly;
    logic                   busy;
    logic                   done;
    logic [10:0]            hint_count;
`ifdef MAKE_HINT_OMEGA_CHECK_EN
    logic                   omega_fail;
`endif

    polyvec_make_hint_stream #(
        .K(K), .N(N), .LANES(LANES), .GAMMA2(G), .OMEGA(OMEGA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a0_in      (a0_in),
        .a1_in      (a1_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .h_out      (h_out),
        .out_poly   (out_poly),
        .busy       (busy),
        .done       (done),
        .hint_count (hint_count)
`ifdef MAKE_HINT_OMEGA_CHECK_EN
        ,
        .omega_fail (omega_fail)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int a0_mem [NB][LANES];
    int a1_mem [NB][LANES];
    logic [LANES-1:0] exp_h [NB];
    int prefix [NB];
    int exp_idx  = 0;
    int done_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit ref_hint(input int a0, input int a1);
        return (a0 > G) || (a0 < -G) || (a0 == -G && a1 != 0);
    endfunction

    function automatic int pick_val(input int sel);
        case (sel)
            0: return 0;
            1: return G;
            2: return G + 1;
            3: return -G;
            4: return -G - 1;
            5: return 32'sh7fffffff;
            6: return 32'sh80000000;
            default: return int'($urandom);
        endcase
    endfunction

    // Expected hint bits per beat, straight from the rule applied to each coefficient.
    task automatic fill(input int mode);
        int run;
        run = 0;
        for (int b = 0; b < NB; b++) begin
            for (int l = 0; l < LANES; l++) begin
                case (mode)
                    0: begin a0_mem[b][l] = G + 1; a1_mem[b][l] = 0; end
                    1: begin
                        case (l)
                            0: begin a0_mem[b][l] = -G; a1_mem[b][l] = 0; end
                            1: begin a0_mem[b][l] = -G; a1_mem[b][l] = 5; end
                            2: begin a0_mem[b][l] = G;  a1_mem[b][l] = b + 1; end
                            default: begin
                                a0_mem[b][l] = (b % 2 == 0) ? -G - 1 : 0;
                                a1_mem[b][l] = (b % 2 == 0) ? 0 : 7;
                            end
                        endcase
                    end
                    2: begin
                        a0_mem[b][l] = pick_val(int'($urandom_range(0, 7)));
                        a1_mem[b][l] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom);
                    end
                    3: begin a0_mem[b][l] = (b < 14) ? G + 1 : 0; a1_mem[b][l] = 3; end
                    default: begin a0_mem[b][l] = (b*LANES + l < 55) ? -G - 1 : -G; a1_mem[b][l] = 0; end
                endcase
                exp_h[b][l] = ref_hint(a0_mem[b][l], a1_mem[b][l]);
                run += exp_h[b][l];
            end
            prefix[b] = run;
        end
    endtask

    // Stream checker: every output handshake must carry the next expected beat.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_idx = 0;
            end else begin
                if (done) done_cnt++;
                if (start && !busy) begin
                    exp_idx = 0;
                end else if (out_valid && out_ready) begin
                    if (exp_idx >= NB) begin
                        check("stream_overrun", exp_idx, NB - 1);
                    end else begin
                        check("h_out", h_out, exp_h[exp_idx]);
                        check("out_poly", out_poly, exp_idx / BPP);
                    end
                    exp_idx++;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   in_ready,   0);
        check({tag, "_out_valid"},  out_valid,  0);
        check({tag, "_h_out"},      h_out,      0);
        check({tag, "_out_poly"},   out_poly,   0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_hint_count"}, hint_count, 0);
`ifdef MAKE_HINT_OMEGA_CHECK_EN
        check({tag, "_omega_fail"}, omega_fail, 0);
`endif
    endtask

    task automatic run_pass(input int mode, input int stall_at, input int rst_at,
                            input int start_at, input bit rand_flow, input int lit_count);
        int d0;
        int tmo;
        bit acc;
        logic [LANES-1:0] hh;
        logic [2:0] pp;
        fill(mode);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("count_clear_on_start", hint_count, 0);
`ifdef MAKE_HINT_OMEGA_CHECK_EN
        check("omega_clear_on_start", omega_fail, 0);
`endif
        d0 = done_cnt;
        for (int b = 0; b < NB; b++) begin
            for (int l = 0; l < LANES; l++) begin
                a0_in[32*l +: 32] = a0_mem[b][l];
                a1_in[32*l +: 32] = a1_mem[b][l];
            end
            if (b == rst_at) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check_all_zero("abort");
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("abort_no_done", done_cnt, d0);
                return;
            end
            if (b == stall_at) begin
                out_ready = 1'b0;
                in_valid = 1'b1;
                @(negedge clk);
                hh = h_out;
                pp = out_poly;
                check("stall_out_valid", out_valid, 1);
                for (int c = 0; c < 10; c++) begin
                    if (c > 0) @(negedge clk);
                    check("stall_h_out", h_out, hh);
                    check("stall_out_poly", out_poly, pp);
                    check("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
            if (b == start_at) start = 1'b1;
            if (rand_flow) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b1;
            end
            acc = 1'b0;
            tmo = 0;
            while (!acc) begin
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                if (!acc) begin
                    tmo++;
                    if (rand_flow) begin
                        in_valid  = ($urandom_range(0, 3) != 0);
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (tmo > 100) begin
                        check("accept_timeout", b, -1);
                        in_valid = 1'b0;
                        out_ready = 1'b1;
                        return;
                    end
                end
            end
            check("hint_count_running", hint_count, prefix[b]);
`ifdef MAKE_HINT_OMEGA_CHECK_EN
            check("omega_fail_running", omega_fail, prefix[b] > OMEGA);
`endif
            if (mode == 1 && b == 0) begin
                check("lit_first_h", h_out, 4'b1010);
                check("lit_first_poly", out_poly, 0);
            end
            if (mode == 1 && b == 1) check("lit_second_h", h_out, 4'b0010);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tmo = 0;
        while (done_cnt == d0 && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("beats_delivered", exp_idx, NB);
        check("busy_after_done", busy, 0);
        check("final_hint_count", hint_count, prefix[NB-1]);
        if (lit_count >= 0) check("lit_final_count", hint_count, lit_count);
`ifdef MAKE_HINT_OMEGA_CHECK_EN
        check("omega_fail_final", omega_fail, prefix[NB-1] > OMEGA);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a0_in = '0;
        a1_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_pass(0, -1, -1, -1, 1'b0, K*N);   // every coefficient above GAMMA2
        run_pass(1, 50, -1, -1, 1'b0, 576);   // boundary lanes + 10-cycle stall
        run_pass(2, -1, 100, -1, 1'b0, -1);   // abort at beat 100
        run_pass(2, -1, -1, -1, 1'b1, -1);    // fresh pass, random flow control
        run_pass(1, -1, -1, 200, 1'b0, 576);  // start during RUN is ignored
`ifdef MAKE_HINT_OMEGA_CHECK_EN
        run_pass(3, -1, -1, -1, 1'b0, 56);
        run_pass(4, -1, -1, -1, 1'b0, 55);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
